// File: rtl/control_sample_buffer.sv
// Sliding window of modulator control vectors, snapshotted into a frozen,
// masked S_matrix once per downsampling period for the downstream FIR adder.
module control_sample_buffer #(
   parameter int unsigned K_MAX     = 256,
   parameter int unsigned N_MAX     = 8,
   parameter int unsigned OSR_WIDTH = 8,
   parameter int unsigned MIN_OSR   = 16
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic                             flush,
   input  logic [N_MAX-1:0]                 s_in,
   input  logic                             s_valid,
   input  logic [OSR_WIDTH-1:0]             osr,
   input  logic [N_MAX-1:0]                 N,
   output logic [K_MAX-1:0][N_MAX-1:0]      S_matrix,
   output logic                             start,
   output logic                             filled
);

   localparam int unsigned FW = $clog2(K_MAX + 1);
   localparam logic [FW-1:0]        FILL_LAST = FW'(K_MAX - 1);
   localparam logic [FW-1:0]        FILL_FULL = FW'(K_MAX);
   localparam logic [OSR_WIDTH-1:0] MIN_P     = OSR_WIDTH'(MIN_OSR);

   typedef enum logic {FILL, RUN} state_t;

   state_t                        state, state_nxt;
   logic [K_MAX-1:0][N_MAX-1:0]   live, live_nxt, masked;
   logic [FW-1:0]                 fill_cnt;
   logic [OSR_WIDTH-1:0]          ds_cnt, period_reg, osr_eff;
   logic                          accept, snap;

   assign accept   = s_valid & ~flush;
   assign osr_eff  = (osr < MIN_P) ? MIN_P : osr;
   // Snapshot sees the window including the sample accepted on this edge.
   assign live_nxt = {live[K_MAX-2:0], s_in};

   always_comb begin
      masked = '0;
      for (int unsigned j = 0; j < K_MAX; j++) begin
         masked[j] = live_nxt[j] & N;
      end
   end

   always_comb begin
      state_nxt = state;
      snap      = 1'b0;
      if (flush) begin
         state_nxt = FILL;
      end else if (accept) begin
         case (state)
            FILL: if (fill_cnt == FILL_LAST) begin
               snap      = 1'b1;
               state_nxt = RUN;
            end
            RUN: if (ds_cnt == period_reg - OSR_WIDTH'(1)) snap = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= FILL;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         live       <= '0;
         S_matrix   <= '0;
         fill_cnt   <= '0;
         ds_cnt     <= '0;
         period_reg <= MIN_P;
         start      <= 1'b0;
         filled     <= 1'b0;
      end else begin
         start <= snap;
         if (flush) begin
            live     <= '0;
            fill_cnt <= '0;
            ds_cnt   <= '0;
            filled   <= 1'b0;
         end else if (accept) begin
            live <= live_nxt;
            if (fill_cnt != FILL_FULL) fill_cnt <= fill_cnt + FW'(1);
            if (state == RUN && !snap) ds_cnt <= ds_cnt + OSR_WIDTH'(1);
            else                       ds_cnt <= '0;
         end
         if (snap) begin
            S_matrix   <= masked;
            period_reg <= osr_eff;
            filled     <= 1'b1;
         end
      end
   end

endmodule
